// File: rtl/display_7seg_mux.sv
// Time-multiplexed hex 7-segment driver: latched display register, 0-F decode,
// configurable polarity and a one-cycle blank at each digit change.
// Optional leading-zero blanking: define DISPLAY_7SEG_SUPRIME_ZEROS_EN.
module display_7seg_mux #(
  parameter int unsigned NUM_DIGITOS     = 4,
  parameter int unsigned DIV_SCAN        = 1000,
  parameter int unsigned SEG_ATIVO_BAIXO = 0,
  parameter int unsigned DIG_ATIVO_BAIXO = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [4*NUM_DIGITOS-1:0]   entrada,
  input  logic [NUM_DIGITOS-1:0]     pontos,
  input  logic                       carregar,
  output logic [0:6]                 saida,
  output logic                       ponto,
  output logic [NUM_DIGITOS-1:0]     digito
);

  localparam int unsigned CNT_W = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam int unsigned DAT_W = 4 * NUM_DIGITOS;

  // "Off" levels double as the polarity XOR masks.
  localparam logic [0:6]             SEG_OFF = (SEG_ATIVO_BAIXO != 0) ? 7'b1111111 : 7'b0000000;
  localparam logic                   PT_OFF  = (SEG_ATIVO_BAIXO != 0);
  localparam logic [NUM_DIGITOS-1:0] DIG_OFF = (DIG_ATIVO_BAIXO != 0) ? {NUM_DIGITOS{1'b1}} : '0;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DAT_W-1:0]       disp_q, disp_d;
  logic [NUM_DIGITOS-1:0] pts_q, pts_d;
  logic [0:6]             saida_q, saida_d;
  logic                   ponto_q, ponto_d;
  logic [NUM_DIGITOS-1:0] digito_q, digito_d;

  logic                   last;
  logic                   blank;
  logic [3:0]             nib;
  logic                   pt_sel;
  logic [NUM_DIGITOS-1:0] dig_raw;
  logic [0:6]             seg_raw;

  // Active-high segment pattern, bit 0 = a ... bit 6 = g.
  function automatic logic [0:6] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b1111110;
      4'h1:    decode = 7'b0110000;
      4'h2:    decode = 7'b1101101;
      4'h3:    decode = 7'b1111001;
      4'h4:    decode = 7'b0110011;
      4'h5:    decode = 7'b1011011;
      4'h6:    decode = 7'b1011111;
      4'h7:    decode = 7'b1110000;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1111011;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b0011111;
      4'hC:    decode = 7'b1001110;
      4'hD:    decode = 7'b0111101;
      4'hE:    decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

`ifdef DISPLAY_7SEG_SUPRIME_ZEROS_EN
  logic [NUM_DIGITOS-1:0] zero_up;

  // zero_up[i]: nibble i and every higher nibble are zero.
  always_comb begin
    logic run;
    run     = 1'b1;
    zero_up = '0;
    for (int i = int'(NUM_DIGITOS) - 1; i >= 0; i--) begin
      run        = run & (disp_q[4*i +: 4] == 4'h0);
      zero_up[i] = run;
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int i = 1; i < int'(NUM_DIGITOS); i++) begin
      if (idx_q == IDX_W'(i)) blank = zero_up[i];
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    last    = (cnt_q == CNT_W'(DIV_SCAN - 1));
    disp_d  = carregar ? entrada : disp_q;
    pts_d   = carregar ? pontos  : pts_q;
    cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    nib     = 4'h0;
    pt_sel  = 1'b0;
    dig_raw = '0;

    if (last) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITOS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Select the current digit; its enable drops on the last cycle of its slot.
    for (int i = 0; i < int'(NUM_DIGITOS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib        = disp_q[4*i +: 4];
        pt_sel     = pts_q[i];
        dig_raw[i] = ~last;
      end
    end

    seg_raw  = blank ? 7'b0000000 : decode(nib);
    saida_d  = seg_raw ^ SEG_OFF;
    ponto_d  = pt_sel ^ PT_OFF;
    digito_d = dig_raw ^ DIG_OFF;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pts_q    <= '0;
      saida_q  <= SEG_OFF;
      ponto_q  <= PT_OFF;
      digito_q <= DIG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pts_q    <= pts_d;
      saida_q  <= saida_d;
      ponto_q  <= ponto_d;
      digito_q <= digito_d;
    end
  end

  assign saida  = saida_q;
  assign ponto  = ponto_q;
  assign digito = digito_q;

endmodule

// File: tb/tb_display_7seg_mux.sv
// Directed bench for display_7seg_mux: one active-high and one active-low
// instance (4 digits, 4-cycle slots) driven from shared stimulus.
module tb_display_7seg_mux;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] entrada;
  logic [3:0]  pontos;
  logic        carregar;
  logic [0:6]  saida, saida_n;
  logic        ponto, ponto_n;
  logic [3:0]  digito, digito_n;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  display_7seg_mux #(
    .NUM_DIGITOS(4), .DIV_SCAN(4), .SEG_ATIVO_BAIXO(0), .DIG_ATIVO_BAIXO(0)
  ) dut (
    .clock(clock), .reset(reset), .entrada(entrada), .pontos(pontos),
    .carregar(carregar), .saida(saida), .ponto(ponto), .digito(digito)
  );

  display_7seg_mux #(
    .NUM_DIGITOS(4), .DIV_SCAN(4), .SEG_ATIVO_BAIXO(1), .DIG_ATIVO_BAIXO(1)
  ) dut_n (
    .clock(clock), .reset(reset), .entrada(entrada), .pontos(pontos),
    .carregar(carregar), .saida(saida_n), .ponto(ponto_n), .digito(digito_n)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance to the first lit cycle of digit 0 (blank/off followed by 0001).
  task automatic sync_d0();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      prev = digito;
      tick();
      if (prev == 4'b0000 && digito == 4'b0001) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_d0: digit 0 start not seen, digito=%b required 0001", digito);
    end
  endtask

  task automatic load(input logic [15:0] val, input logic [3:0] pts);
    entrada  = val;
    pontos   = pts;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_dig;
    reset = 1'b1; carregar = 1'b0; entrada = '0; pontos = '0;
    tick(); tick();
    checks++; if (saida !== 7'b0000000) begin errors++; $display("FAIL reset_saida: got %b required 0000000", saida); end
    checks++; if (ponto !== 1'b0) begin errors++; $display("FAIL reset_ponto: got %b required 0", ponto); end
    checks++; if (digito !== 4'b0000) begin errors++; $display("FAIL reset_digito: got %b required 0000", digito); end
    checks++; if (saida_n !== 7'b1111111) begin errors++; $display("FAIL reset_saida_n: got %b required 1111111", saida_n); end
    checks++; if (ponto_n !== 1'b1) begin errors++; $display("FAIL reset_ponto_n: got %b required 1", ponto_n); end
    checks++; if (digito_n !== 4'b1111) begin errors++; $display("FAIL reset_digito_n: got %b required 1111", digito_n); end
    reset = 1'b0;
    checks++; if (digito !== 4'b0000) begin errors++; $display("FAIL release_digito: got %b required 0000", digito); end
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_dig = ((i % 4) == 3) ? 4'b0000 : 4'(1 << (i / 4));
      checks++;
      if (digito !== exp_dig) begin
        errors++; $display("FAIL scan_seq[%0d]: digito=%b required %b", i, digito, exp_dig);
      end
    end
    tick();
    checks++; if (digito !== 4'b0001) begin errors++; $display("FAIL scan_wrap: digito=%b required 0001", digito); end
  endtask

  task automatic test_scan();
    logic [0:6] exp_seg [4];
    logic       exp_pt  [4];
    exp_seg = '{7'b1111110, 7'b1110111, 7'b1111011, 7'b1000111};
    exp_pt  = '{1'b0, 1'b0, 1'b1, 1'b0};
    load(16'hF9A0, 4'b0100);
    sync_d0();
    for (int d = 0; d < 4; d++) begin
      checks++; if (saida !== exp_seg[d]) begin errors++; $display("FAIL scan_saida d%0d: got %b required %b", d, saida, exp_seg[d]); end
      checks++; if (ponto !== exp_pt[d]) begin errors++; $display("FAIL scan_ponto d%0d: got %b required %b", d, ponto, exp_pt[d]); end
      checks++; if (digito !== 4'(1 << d)) begin errors++; $display("FAIL scan_digito d%0d: got %b required %b", d, digito, 4'(1 << d)); end
      tick(); tick(); tick();
      checks++; if (digito !== 4'b0000) begin errors++; $display("FAIL blank_digito d%0d: got %b required 0000", d, digito); end
      checks++; if (saida !== exp_seg[d]) begin errors++; $display("FAIL blank_saida d%0d: got %b required %b", d, saida, exp_seg[d]); end
      tick();
    end
  endtask

  task automatic test_decode();
    logic [0:6] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    pontos = '0;
    for (int v = 0; v < 16; v++) begin
      entrada  = {12'h000, 4'(v)};
      carregar = 1'b1;
      sync_d0();
      checks++;
      if (saida !== tbl[v]) begin
        errors++; $display("FAIL decode[%0h]: got %b required %b", v, saida, tbl[v]);
      end
    end
    carregar = 1'b0;
  endtask

  task automatic test_load();
    load(16'h1234, 4'b0000);
    sync_d0();
    entrada = 16'h5675;
    tick(); tick();
    checks++; if (saida !== 7'b0110011) begin errors++; $display("FAIL noload_saida: got %b required 0110011", saida); end
    sync_d0();
    entrada  = 16'h5675;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    checks++; if (saida !== 7'b0110011) begin errors++; $display("FAIL load_edge_saida: got %b required 0110011", saida); end
    checks++; if (digito !== 4'b0001) begin errors++; $display("FAIL load_edge_digito: got %b required 0001", digito); end
    tick();
    checks++; if (saida !== 7'b1011011) begin errors++; $display("FAIL load_vis_saida: got %b required 1011011", saida); end
    checks++; if (digito !== 4'b0001) begin errors++; $display("FAIL load_vis_digito: got %b required 0001", digito); end
  endtask

  task automatic test_polarity();
    load(16'h0008, 4'b0000);
    sync_d0();
    checks++; if (saida_n !== 7'b0000000) begin errors++; $display("FAIL pol_saida_n: got %b required 0000000", saida_n); end
    checks++; if (digito_n !== 4'b1110) begin errors++; $display("FAIL pol_digito_n: got %b required 1110", digito_n); end
    checks++; if (ponto_n !== 1'b1) begin errors++; $display("FAIL pol_ponto_n: got %b required 1", ponto_n); end
    checks++; if (saida !== 7'b1111111) begin errors++; $display("FAIL pol_saida: got %b required 1111111", saida); end
    tick(); tick(); tick();
    checks++; if (digito_n !== 4'b1111) begin errors++; $display("FAIL pol_blank_n: got %b required 1111", digito_n); end
    checks++; if (saida_n !== 7'b0000000) begin errors++; $display("FAIL pol_blank_saida_n: got %b required 0000000", saida_n); end
  endtask

  task automatic test_suppress();
    logic [0:6] exp_seg [4];
`ifdef DISPLAY_7SEG_SUPRIME_ZEROS_EN
    exp_seg = '{7'b1111110, 7'b1111001, 7'b0000000, 7'b0000000};
`else
    exp_seg = '{7'b1111110, 7'b1111001, 7'b1111110, 7'b1111110};
`endif
    load(16'h0030, 4'b1000);
    sync_d0();
    for (int d = 0; d < 4; d++) begin
      checks++; if (saida !== exp_seg[d]) begin errors++; $display("FAIL supp_saida d%0d: got %b required %b", d, saida, exp_seg[d]); end
      checks++; if (saida_n !== ~exp_seg[d]) begin errors++; $display("FAIL supp_saida_n d%0d: got %b required %b", d, saida_n, ~exp_seg[d]); end
      checks++; if (ponto !== (d == 3)) begin errors++; $display("FAIL supp_ponto d%0d: got %b required %b", d, ponto, (d == 3)); end
      tick(); tick(); tick(); tick();
    end
  endtask

  task automatic test_reset_mid();
    sync_d0();
    tick(); tick(); tick(); tick();
    checks++; if (digito !== 4'b0010) begin errors++; $display("FAIL mid_pre_digito: got %b required 0010", digito); end
    reset = 1'b1;
    tick();
    checks++; if (digito !== 4'b0000) begin errors++; $display("FAIL mid_rst_digito: got %b required 0000", digito); end
    checks++; if (saida !== 7'b0000000) begin errors++; $display("FAIL mid_rst_saida: got %b required 0000000", saida); end
    checks++; if (digito_n !== 4'b1111) begin errors++; $display("FAIL mid_rst_digito_n: got %b required 1111", digito_n); end
    reset = 1'b0;
    tick();
    checks++; if (digito !== 4'b0001) begin errors++; $display("FAIL mid_restart_digito: got %b required 0001", digito); end
    checks++; if (saida !== 7'b1111110) begin errors++; $display("FAIL mid_restart_saida: got %b required 1111110", saida); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_load();
    test_polarity();
    test_suppress();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
